ro_buffer_mc: RTL and testbench

Parametrised multi-commit reorder buffer: the in-order retirement point of the out-of-order core. It allocates one entry per cycle from the issuer, collects results from the LSB and RSS writeback buses, and serves operand lookups (with same-cycle bypass). It retires up to COMMIT_WIDTH entries per cycle to the register file, handshakes store commits with the LSB, and raises a flush on branch mispredict.

---
 rtl/ro_buffer_mc_pkg.sv | 17 +
 rtl/ro_commit_scan.sv | 74 +++++++
 rtl/ro_buffer_mc.sv | 228 ++++++++++++++++++++++
 tb/tb_ro_buffer_mc.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ro_buffer_mc_pkg.sv
// Shared definitions for the reorder buffer: entry kinds, default widths and the
// reserved "no tag" value.
package ro_buffer_mc_pkg;

  localparam int RO_DEPTH = 16;
  localparam int RO_TAG_W = $clog2(RO_DEPTH + 1);
  localparam int RO_XLEN  = 32;
  localparam int REG_ID_W = 5;
  localparam int TAG_NONE = 0;

  typedef enum logic [1:0] {
    RO_DEFAULT = 2'd0,
    RO_BRANCH  = 2'd1,
    RO_STORE   = 2'd2
  } ro_kind_e;

endpackage

// File: rtl/ro_commit_scan.sv
// Combinational in-order retire scan over the head window of the reorder buffer.
// Produces the retire mask/count, the head store request and the mispredict redirect.
module ro_commit_scan
  import ro_buffer_mc_pkg::*;
#(
  parameter int COMMIT_WIDTH = 2,
  parameter int XLEN         = RO_XLEN,
  parameter int CNT_W        = $clog2(COMMIT_WIDTH + 1)
) (
  input  logic [COMMIT_WIDTH-1:0] lane_valid_i,
  input  logic [COMMIT_WIDTH-1:0] lane_ready_i,
  input  ro_kind_e                lane_kind_i    [COMMIT_WIDTH],
  input  logic [XLEN-1:0]         lane_pred_pc_i [COMMIT_WIDTH],
  input  logic [XLEN-1:0]         lane_next_pc_i [COMMIT_WIDTH],
  input  logic                    store_ready_i,
  output logic [COMMIT_WIDTH-1:0] retire_mask_o,
  output logic [CNT_W-1:0]        retire_cnt_o,
  output logic                    store_req_o,
  output logic                    mispredict_o,
  output logic [XLEN-1:0]         redirect_pc_o
);

  logic stop;

  always_comb begin
    retire_mask_o = '0;
    retire_cnt_o  = '0;
    store_req_o   = 1'b0;
    mispredict_o  = 1'b0;
    redirect_pc_o = '0;
    stop          = 1'b0;
    for (int unsigned l = 0; l < COMMIT_WIDTH; l++) begin
      if (!stop) begin
        if (!lane_valid_i[l]) begin
          stop = 1'b1;
        end else begin
          case (lane_kind_i[l])
            // Stores only commit alone from lane 0, gated by the LSB handshake.
            RO_STORE: begin
              stop = 1'b1;
              if (l == 0) begin
                store_req_o = 1'b1;
                if (store_ready_i) begin
                  retire_mask_o[l] = 1'b1;
                  retire_cnt_o     = retire_cnt_o + CNT_W'(1);
                end
              end
            end
            RO_BRANCH: begin
              stop = 1'b1;
              if (lane_ready_i[l]) begin
                retire_mask_o[l] = 1'b1;
                retire_cnt_o     = retire_cnt_o + CNT_W'(1);
                if (lane_pred_pc_i[l] != lane_next_pc_i[l]) begin
                  mispredict_o  = 1'b1;
                  redirect_pc_o = lane_next_pc_i[l];
                end
              end
            end
            default: begin
              if (lane_ready_i[l]) begin
                retire_mask_o[l] = 1'b1;
                retire_cnt_o     = retire_cnt_o + CNT_W'(1);
              end else begin
                stop = 1'b1;
              end
            end
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/ro_buffer_mc.sv
// Multi-commit reorder buffer: allocates from the issuer, collects LSB/RSS writebacks,
// serves bypassed operand lookups and retires up to COMMIT_WIDTH entries per cycle.
module ro_buffer_mc
  import ro_buffer_mc_pkg::*;
#(
  parameter int DEPTH        = RO_DEPTH,
  parameter int TAG_W        = $clog2(DEPTH + 1),
  parameter int COMMIT_WIDTH = 2,
  parameter int XLEN         = RO_XLEN
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             rdy,
  output logic                             full,
  input  logic                             alloc_valid,
  input  logic [1:0]                       alloc_kind,
  input  logic [REG_ID_W-1:0]              alloc_rd,
  input  logic [XLEN-1:0]                  alloc_pred_pc,
  output logic [TAG_W-1:0]                 alloc_tag,
  input  logic [TAG_W-1:0]                 qj,
  input  logic [TAG_W-1:0]                 qk,
  output logic                             vj_valid,
  output logic                             vk_valid,
  output logic [XLEN-1:0]                  vj,
  output logic [XLEN-1:0]                  vk,
  input  logic [TAG_W-1:0]                 lsb_tag,
  input  logic [XLEN-1:0]                  lsb_value,
  input  logic [TAG_W-1:0]                 rss_tag,
  input  logic [XLEN-1:0]                  rss_value,
  input  logic [XLEN-1:0]                  rss_next_pc,
  output logic                             store_commit_valid,
  input  logic                             store_commit_ready,
  output logic [COMMIT_WIDTH-1:0]          commit_valid,
  output logic [COMMIT_WIDTH*TAG_W-1:0]    commit_tag,
  output logic [COMMIT_WIDTH*REG_ID_W-1:0] commit_rd,
  output logic [COMMIT_WIDTH*XLEN-1:0]     commit_value,
  output logic                             flush_out,
  output logic [XLEN-1:0]                  flush_pc,
  input  logic                             flush_in
);

  localparam int          NSLOT   = 1 << TAG_W;
  localparam int          CNT_W   = $clog2(COMMIT_WIDTH + 1);
  localparam int unsigned DEPTH_U = DEPTH;

  typedef logic [TAG_W-1:0] tag_t;

  // Tags live in 1..DEPTH; slot index equals the tag itself.
  function automatic tag_t tag_add(tag_t t, int unsigned n);
    int unsigned s;
    s = 32'(t) + n;
    if (s > DEPTH_U) s = s - DEPTH_U;
    return tag_t'(s);
  endfunction

  tag_t                head_q, head_d, tail_q, tail_d, count_q, count_d;
  logic                ready_q   [NSLOT];
  logic                ready_d   [NSLOT];
  ro_kind_e            kind_q    [NSLOT];
  ro_kind_e            kind_d    [NSLOT];
  logic [REG_ID_W-1:0] rd_q      [NSLOT];
  logic [REG_ID_W-1:0] rd_d      [NSLOT];
  logic [XLEN-1:0]     value_q   [NSLOT];
  logic [XLEN-1:0]     value_d   [NSLOT];
  logic [XLEN-1:0]     pred_pc_q [NSLOT];
  logic [XLEN-1:0]     pred_pc_d [NSLOT];
  logic [XLEN-1:0]     next_pc_q [NSLOT];
  logic [XLEN-1:0]     next_pc_d [NSLOT];

  logic [COMMIT_WIDTH-1:0]          commit_valid_q, commit_valid_d;
  logic [COMMIT_WIDTH*TAG_W-1:0]    commit_tag_q, commit_tag_d;
  logic [COMMIT_WIDTH*REG_ID_W-1:0] commit_rd_q, commit_rd_d;
  logic [COMMIT_WIDTH*XLEN-1:0]     commit_value_q, commit_value_d;
  logic                             flush_out_q, flush_out_d;
  logic [XLEN-1:0]                  flush_pc_q, flush_pc_d;

  tag_t                    win_tag      [COMMIT_WIDTH];
  logic [COMMIT_WIDTH-1:0] lane_valid, lane_ready;
  ro_kind_e                lane_kind    [COMMIT_WIDTH];
  logic [XLEN-1:0]         lane_pred_pc [COMMIT_WIDTH];
  logic [XLEN-1:0]         lane_next_pc [COMMIT_WIDTH];
  logic [COMMIT_WIDTH-1:0] retire_mask;
  logic [CNT_W-1:0]        retire_cnt;
  logic                    store_req, mispredict, alloc_fire;
  logic [XLEN-1:0]         redirect_pc;

  always_comb begin
    lane_valid = '0;
    lane_ready = '0;
    for (int unsigned l = 0; l < COMMIT_WIDTH; l++) begin
      win_tag[l]      = tag_add(head_q, l);
      lane_valid[l]   = tag_t'(l) < count_q;
      lane_ready[l]   = ready_q[win_tag[l]];
      lane_kind[l]    = kind_q[win_tag[l]];
      lane_pred_pc[l] = pred_pc_q[win_tag[l]];
      lane_next_pc[l] = next_pc_q[win_tag[l]];
    end
  end

  ro_commit_scan #(
    .COMMIT_WIDTH(COMMIT_WIDTH),
    .XLEN        (XLEN),
    .CNT_W       (CNT_W)
  ) u_scan (
    .lane_valid_i  (lane_valid),
    .lane_ready_i  (lane_ready),
    .lane_kind_i   (lane_kind),
    .lane_pred_pc_i(lane_pred_pc),
    .lane_next_pc_i(lane_next_pc),
    .store_ready_i (store_commit_ready),
    .retire_mask_o (retire_mask),
    .retire_cnt_o  (retire_cnt),
    .store_req_o   (store_req),
    .mispredict_o  (mispredict),
    .redirect_pc_o (redirect_pc)
  );

  always_comb begin
    ready_d        = ready_q;
    kind_d         = kind_q;
    rd_d           = rd_q;
    value_d        = value_q;
    pred_pc_d      = pred_pc_q;
    next_pc_d      = next_pc_q;
    tail_d         = tail_q;
    commit_valid_d = '0;
    commit_tag_d   = '0;
    commit_rd_d    = '0;
    commit_value_d = '0;
    flush_out_d    = mispredict;
    flush_pc_d     = redirect_pc;
    alloc_fire     = alloc_valid && (count_q != tag_t'(DEPTH));

    // Retire first so a writeback/alloc in the same cycle lands on a clean slot.
    for (int unsigned l = 0; l < COMMIT_WIDTH; l++) begin
      if (retire_mask[l]) begin
        commit_valid_d[l]                         = 1'b1;
        commit_tag_d[l*TAG_W +: TAG_W]            = win_tag[l];
        commit_rd_d[l*REG_ID_W +: REG_ID_W]       = (lane_kind[l] == RO_STORE) ? '0 : rd_q[win_tag[l]];
        commit_value_d[l*XLEN +: XLEN]            = value_q[win_tag[l]];
        ready_d[win_tag[l]]                       = 1'b0;
        kind_d[win_tag[l]]                        = RO_DEFAULT;
      end
    end
    head_d = tag_add(head_q, 32'(retire_cnt));

    if (lsb_tag != tag_t'(TAG_NONE)) begin
      ready_d[lsb_tag] = 1'b1;
      value_d[lsb_tag] = lsb_value;
    end
    if (rss_tag != tag_t'(TAG_NONE)) begin
      ready_d[rss_tag]   = 1'b1;
      value_d[rss_tag]   = rss_value;
      next_pc_d[rss_tag] = rss_next_pc;
    end

    if (alloc_fire) begin
      ready_d[tail_q]   = 1'b0;
      kind_d[tail_q]    = (alloc_kind == 2'd1) ? RO_BRANCH :
                          (alloc_kind == 2'd2) ? RO_STORE  : RO_DEFAULT;
      rd_d[tail_q]      = alloc_rd;
      pred_pc_d[tail_q] = alloc_pred_pc;
      tail_d            = tag_add(tail_q, 1);
    end
    count_d = count_q + tag_t'(alloc_fire) - tag_t'(retire_cnt);
  end

  always_ff @(posedge clk) begin
    if (rst || (rdy && flush_in)) begin
      head_q         <= tag_t'(1);
      tail_q         <= tag_t'(1);
      count_q        <= '0;
      for (int unsigned i = 0; i < NSLOT; i++) begin
        ready_q[i] <= 1'b0;
        kind_q[i]  <= RO_DEFAULT;
      end
      commit_valid_q <= '0;
      commit_tag_q   <= '0;
      commit_rd_q    <= '0;
      commit_value_q <= '0;
      flush_out_q    <= 1'b0;
      flush_pc_q     <= '0;
    end else if (rdy) begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      ready_q        <= ready_d;
      kind_q         <= kind_d;
      rd_q           <= rd_d;
      value_q        <= value_d;
      pred_pc_q      <= pred_pc_d;
      next_pc_q      <= next_pc_d;
      commit_valid_q <= commit_valid_d;
      commit_tag_q   <= commit_tag_d;
      commit_rd_q    <= commit_rd_d;
      commit_value_q <= commit_value_d;
      flush_out_q    <= flush_out_d;
      flush_pc_q     <= flush_pc_d;
    end
  end

  // Operand lookup: stored result first, then same-cycle bus bypass with RSS priority.
  always_comb begin
    vj_valid = 1'b0;
    vj       = '0;
    if (qj == tag_t'(TAG_NONE))   vj_valid = 1'b1;
    else if (ready_q[qj])         begin vj_valid = 1'b1; vj = value_q[qj]; end
    else if (rss_tag == qj)       begin vj_valid = 1'b1; vj = rss_value;   end
    else if (lsb_tag == qj)       begin vj_valid = 1'b1; vj = lsb_value;   end
    vk_valid = 1'b0;
    vk       = '0;
    if (qk == tag_t'(TAG_NONE))   vk_valid = 1'b1;
    else if (ready_q[qk])         begin vk_valid = 1'b1; vk = value_q[qk]; end
    else if (rss_tag == qk)       begin vk_valid = 1'b1; vk = rss_value;   end
    else if (lsb_tag == qk)       begin vk_valid = 1'b1; vk = lsb_value;   end
  end

  assign full               = count_q >= tag_t'(DEPTH - 1);
  assign alloc_tag          = tail_q;
  assign store_commit_valid = store_req;
  assign commit_valid       = commit_valid_q;
  assign commit_tag         = commit_tag_q;
  assign commit_rd          = commit_rd_q;
  assign commit_value       = commit_value_q;
  assign flush_out          = flush_out_q;
  assign flush_pc           = flush_pc_q;

endmodule

// File: tb/tb_ro_buffer_mc.sv
// Directed self-checking bench for ro_buffer_mc (DEPTH=16, COMMIT_WIDTH=2, XLEN=32).
module tb_ro_buffer_mc;

  localparam int DEPTH = 16;
  localparam int TAG_W = 5;
  localparam int CW    = 2;
  localparam int XLEN  = 32;

  logic              clk = 1'b0;
  logic              rst, rdy, full, alloc_valid;
  logic [1:0]        alloc_kind;
  logic [4:0]        alloc_rd;
  logic [XLEN-1:0]   alloc_pred_pc;
  logic [TAG_W-1:0]  alloc_tag, qj, qk, lsb_tag, rss_tag;
  logic              vj_valid, vk_valid;
  logic [XLEN-1:0]   vj, vk, lsb_value, rss_value, rss_next_pc, flush_pc;
  logic              store_commit_valid, store_commit_ready, flush_out, flush_in;
  logic [CW-1:0]     commit_valid;
  logic [CW*TAG_W-1:0] commit_tag;
  logic [CW*5-1:0]   commit_rd;
  logic [CW*XLEN-1:0] commit_value;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ro_buffer_mc #(
    .DEPTH(DEPTH), .TAG_W(TAG_W), .COMMIT_WIDTH(CW), .XLEN(XLEN)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .full(full),
    .alloc_valid(alloc_valid), .alloc_kind(alloc_kind), .alloc_rd(alloc_rd),
    .alloc_pred_pc(alloc_pred_pc), .alloc_tag(alloc_tag),
    .qj(qj), .qk(qk), .vj_valid(vj_valid), .vk_valid(vk_valid), .vj(vj), .vk(vk),
    .lsb_tag(lsb_tag), .lsb_value(lsb_value),
    .rss_tag(rss_tag), .rss_value(rss_value), .rss_next_pc(rss_next_pc),
    .store_commit_valid(store_commit_valid), .store_commit_ready(store_commit_ready),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_rd(commit_rd),
    .commit_value(commit_value), .flush_out(flush_out), .flush_pc(flush_pc),
    .flush_in(flush_in)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid = 1'b0; alloc_kind = 2'd0; alloc_rd = '0; alloc_pred_pc = '0;
    qj = '0; qk = '0; lsb_tag = '0; lsb_value = '0;
    rss_tag = '0; rss_value = '0; rss_next_pc = '0;
    store_commit_ready = 1'b0; flush_in = 1'b0;
  endtask

  // Issuer protocol: never allocate into a completely full buffer.
  always @(negedge clk)
    if (!rst && rdy && !flush_in && alloc_valid)
      assert (dut.count_q != TAG_W'(DEPTH)) else begin
        fails++;
        $error("FAIL alloc_overflow: count %0d", dut.count_q);
      end

  initial begin
    idle();
    rdy = 1'b1;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_flush_out", flush_out, 0);
    chk("rst_full", full, 0);
    chk("rst_store_valid", store_commit_valid, 0);
    chk("rst_alloc_tag", alloc_tag, 1);
    chk("rst_count", dut.count_q, 0);

    // Three normal entries, results arrive out of order, two retire together.
    for (int i = 1; i <= 3; i++) begin
      alloc_valid = 1'b1; alloc_kind = 2'd0; alloc_rd = 5'(i);
      #1 chk("alloc_tag_seq", alloc_tag, 64'(i));
      tick();
    end
    alloc_valid = 1'b0;
    rss_tag = 5'd3; rss_value = 32'h33; qj = 5'd3; qk = 5'd2;
    #1;
    chk("bypass_vj_valid", vj_valid, 1);
    chk("bypass_vj", vj, 64'h33);
    chk("pending_vk_valid", vk_valid, 0);
    tick();
    rss_tag = 5'd2; rss_value = 32'h22; tick();
    rss_tag = 5'd1; rss_value = 32'h11; tick();
    chk("no_commit_yet", commit_valid, 0);
    idle();
    #1;
    chk("tag0_vj_valid", vj_valid, 1);
    chk("tag0_vj", vj, 0);
    tick();
    chk("dual_commit_valid", commit_valid, 64'h3);
    chk("dual_commit_tag", commit_tag, 64'h041);
    chk("dual_commit_rd", commit_rd, 64'h041);
    chk("dual_commit_value", commit_value, 64'h00000022_00000011);
    tick();
    chk("single_commit_valid", commit_valid, 64'h1);
    chk("single_commit_tag", commit_tag, 64'h003);
    chk("single_commit_value", commit_value, 64'h33);
    chk("empty_count", dut.count_q, 0);
    tick();
    chk("commit_idle", commit_valid, 0);

    // Store at head waits on the LSB handshake.
    rst = 1'b1; tick(); rst = 1'b0;
    alloc_valid = 1'b1; alloc_kind = 2'd2; alloc_rd = 5'd7; tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      #1 chk("store_valid_held", store_commit_valid, 1);
      tick();
      chk("store_no_commit", commit_valid, 0);
    end
    store_commit_ready = 1'b1; tick(); store_commit_ready = 1'b0;
    chk("store_commit_valid", commit_valid, 64'h1);
    chk("store_commit_tag", commit_tag, 64'h001);
    chk("store_commit_rd", commit_rd, 0);
    chk("store_head", dut.head_q, 2);
    chk("store_valid_drop", store_commit_valid, 0);

    // Mispredicted branch raises a one-cycle flush.
    alloc_valid = 1'b1; alloc_kind = 2'd1; alloc_rd = 5'd5; alloc_pred_pc = 32'h100;
    #1 chk("branch_alloc_tag", alloc_tag, 2);
    tick();
    idle();
    rss_tag = 5'd2; rss_value = 32'h99; rss_next_pc = 32'h104; tick();
    idle();
    tick();
    chk("flush_pulse", flush_out, 1);
    chk("flush_pc", flush_pc, 64'h104);
    chk("branch_commit_tag", commit_tag, 64'h002);
    chk("branch_commit_rd", commit_rd, 64'h005);
    tick();
    chk("flush_pulse_end", flush_out, 0);
    alloc_valid = 1'b1; alloc_rd = 5'd9; tick(); tick();
    alloc_valid = 1'b0; flush_in = 1'b1; tick(); flush_in = 1'b0;
    chk("flush_alloc_tag", alloc_tag, 1);
    chk("flush_count", dut.count_q, 0);
    chk("flush_commit_valid", commit_valid, 0);

    // Fill to DEPTH-1, then retire and allocate together across the wrap.
    for (int i = 1; i <= DEPTH - 1; i++) begin
      alloc_valid = 1'b1; alloc_kind = 2'd0; alloc_rd = 5'(i);
      tick();
      if (i == DEPTH - 2) chk("full_below", full, 0);
    end
    alloc_valid = 1'b0;
    chk("full_set", full, 1);
    chk("full_count", dut.count_q, 15);
    chk("full_alloc_tag", alloc_tag, 16);
    rss_tag = 5'd1; rss_value = 32'hA1; tick(); rss_tag = '0;
    alloc_valid = 1'b1; alloc_rd = 5'd16; tick(); alloc_valid = 1'b0;
    chk("wrap_count", dut.count_q, 15);
    chk("wrap_commit_tag", commit_tag, 64'h001);
    chk("wrap_commit_value", commit_value, 64'hA1);
    chk("wrap_alloc_tag", alloc_tag, 1);
    rss_tag = 5'd2; rss_value = 32'hA2; tick(); rss_tag = '0;
    alloc_valid = 1'b1; alloc_rd = 5'd17; tick(); alloc_valid = 1'b0;
    chk("wrap2_count", dut.count_q, 15);
    chk("wrap2_alloc_tag", alloc_tag, 2);
    chk("wrap2_head", dut.head_q, 3);

    // Equal tags on both buses: RSS wins for bypass and storage.
    lsb_tag = 5'd3; lsb_value = 32'hBAD; rss_tag = 5'd3; rss_value = 32'h600D; qj = 5'd3;
    #1;
    chk("tie_vj_valid", vj_valid, 1);
    chk("tie_vj", vj, 64'h600D);
    tick();
    idle();
    qk = 5'd3;
    #1 chk("tie_vk_stored", vk, 64'h600D);
    tick();
    chk("tie_commit_tag", commit_tag, 64'h003);
    chk("tie_commit_value", commit_value, 64'h600D);

    // rdy low freezes state and outputs.
    idle();
    rdy = 1'b0; alloc_valid = 1'b1; rss_tag = 5'd4; rss_value = 32'h44;
    tick(); tick();
    chk("hold_count", dut.count_q, 14);
    chk("hold_alloc_tag", alloc_tag, 2);
    chk("hold_commit_valid", commit_valid, 64'h1);
    chk("hold_commit_tag", commit_tag, 64'h003);
    idle();
    rdy = 1'b1;
    tick();
    chk("hold_no_writeback", commit_valid, 0);

    // Reset mid-stream with a retire pending; rst overrides rdy.
    flush_in = 1'b1; tick(); flush_in = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      alloc_valid = 1'b1; alloc_rd = 5'(i); tick();
    end
    alloc_valid = 1'b0;
    rss_tag = 5'd1; rss_value = 32'h55; tick(); rss_tag = '0;
    rst = 1'b1; rdy = 1'b0; tick(); rst = 1'b0; rdy = 1'b1;
    chk("mid_rst_commit_valid", commit_valid, 0);
    chk("mid_rst_commit_value", commit_value, 0);
    chk("mid_rst_flush_out", flush_out, 0);
    chk("mid_rst_full", full, 0);
    chk("mid_rst_store_valid", store_commit_valid, 0);
    chk("mid_rst_count", dut.count_q, 0);
    chk("mid_rst_alloc_tag", alloc_tag, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
